machine_timer: RTL

//   Memory-mapped RISC-V machine timer (mtime/mtimecmp) that drives riscv_core.timer_interrupt.

---
 rtl/machine_timer_pkg.sv | 21 ++
 rtl/machine_timer_if.sv | 22 ++
 rtl/machine_timer_prescaler.sv | 29 ++
 rtl/machine_timer.sv | 118 +++++++++++
 4 files changed

// File: rtl/machine_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register word map,
// CTRL bit positions and the default compare reset value.
package machine_timer_pkg;

   typedef enum logic [2:0] {
      REG_MTIME_LO = 3'd0,
      REG_MTIME_HI = 3'd1,
      REG_CMP_LO   = 3'd2,
      REG_CMP_HI   = 3'd3,
      REG_CTRL     = 3'd4,
      REG_STATUS   = 3'd5,
      REG_RSVD6    = 3'd6,
      REG_RSVD7    = 3'd7
   } reg_e;

   localparam int unsigned CTRL_EN = 0;
   localparam int unsigned CTRL_IE = 1;

   localparam logic [63:0] CMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/machine_timer_if.sv
// Word-oriented data-memory bus slice seen by the machine timer.
interface machine_timer_if;

   logic        bus_sel;
   logic [4:0]  bus_addr;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;

   modport master (
      output bus_sel, bus_addr, bus_we, bus_re, bus_wdata,
      input  bus_rdata, bus_rvalid
   );

   modport slave (
      input  bus_sel, bus_addr, bus_we, bus_re, bus_wdata,
      output bus_rdata, bus_rvalid
   );

endinterface

// File: rtl/machine_timer_prescaler.sv
// Clock divider for mtime: pulses tick once every PRESCALE enabled cycles.
module timer_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] count;

   assign tick = en && (count == LAST);

   // Clearing dominates so a software write to mtime restarts a full period.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? 16'd0 : count + 16'd1;
      end
   end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with CTRL/STATUS registers,
// latency-1 registered reads and a registered level interrupt.
module machine_timer
   import machine_timer_pkg::*;
#(
   parameter int unsigned PRESCALE  = 1,
   parameter logic [63:0] CMP_RESET = CMP_RESET_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   machine_timer_if.slave bus,
   output logic           timer_interrupt
);

   reg_e        sel_reg;
   logic        wr;
   logic        rd;
   logic        mtime_wr;
   logic        tick;
   logic        pend;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        en;
   logic        ie;
   logic [31:0] hi_shadow;
   logic [31:0] rd_mux;
   logic [31:0] rdata_p1;
   logic        rvalid_p1;
   logic        irq_p1;
   logic        unused_addr;

   // Byte lanes are not supported; only whole words are addressed.
   assign unused_addr = ^bus.bus_addr[1:0];

   assign sel_reg  = reg_e'(bus.bus_addr[4:2]);
   assign wr       = bus.bus_sel & bus.bus_we;
   assign rd       = bus.bus_sel & bus.bus_re;
   assign mtime_wr = wr && (sel_reg == REG_MTIME_LO || sel_reg == REG_MTIME_HI);
   assign pend     = (mtime >= mtimecmp);

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (mtime_wr),
      .tick (tick)
   );

   // A software write to either half suppresses the increment entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
      end else if (wr && sel_reg == REG_MTIME_LO) begin
         mtime[31:0] <= bus.bus_wdata;
      end else if (wr && sel_reg == REG_MTIME_HI) begin
         mtime[63:32] <= bus.bus_wdata;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtimecmp <= CMP_RESET;
         en       <= 1'b0;
         ie       <= 1'b0;
      end else if (wr) begin
         case (sel_reg)
            REG_CMP_LO: mtimecmp[31:0]  <= bus.bus_wdata;
            REG_CMP_HI: mtimecmp[63:32] <= bus.bus_wdata;
            REG_CTRL: begin
               en <= bus.bus_wdata[CTRL_EN];
               ie <= bus.bus_wdata[CTRL_IE];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (sel_reg)
         REG_MTIME_LO: rd_mux = mtime[31:0];
         REG_MTIME_HI: rd_mux = hi_shadow;
         REG_CMP_LO:   rd_mux = mtimecmp[31:0];
         REG_CMP_HI:   rd_mux = mtimecmp[63:32];
         REG_CTRL:     rd_mux = {30'd0, ie, en};
         REG_STATUS:   rd_mux = {31'd0, pend};
         default:      rd_mux = '0;
      endcase
   end

   // Stage p1: registered read response, upper-half snapshot and interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_p1  <= '0;
         rvalid_p1 <= 1'b0;
         hi_shadow <= '0;
         irq_p1    <= 1'b0;
      end else begin
         rvalid_p1 <= rd;
         irq_p1    <= pend & ie;
         if (rd) begin
            rdata_p1 <= rd_mux;
            if (sel_reg == REG_MTIME_LO) begin
               hi_shadow <= mtime[63:32];
            end
         end
      end
   end

   assign bus.bus_rdata   = rdata_p1;
   assign bus.bus_rvalid  = rvalid_p1;
   assign timer_interrupt = irq_p1;

endmodule
